sba_stage: RTL
==============

# sba_stage

Single-issue pipeline stage that sits directly upstream of the delayed-execute (REEXE) stage. It latches one instruction from EXE, computes its ALU result, and presents the writeback number, virtual address and result to REEXE through the valid/okToChange interlock. Single-cycle ALU ops are produced in the capture cycle. Signed and unsigned divide/remainder use an iterative 32-step divider and stall the stage until the result is ready.

## Interface
Parameters:
- none. Widths come from the shared defines `GPR_NUM` [4:0], `SINGLE_WORD` [31:0] and `ALU_OP` [4:0].

Ports:
- clk  in  1  the only clock
- rst  in  1  synchronous, active-low reset
- EXE_valid_w_i  in  1  EXE offers an instruction this cycle
- REEXE_okToChange_w_i  in  1  REEXE can accept data this cycle
- flush_w_i  in  1  exception/redirect kill; clears the stage at the next edge
- EXE_writeNum_i  in  `GPR_NUM`  destination GPR; 0 means no writeback
- EXE_VAddr_i  in  `SINGLE_WORD`  instruction PC, used for debug and exceptions
- EXE_aluOp_i  in  `ALU_OP`  operation code
- EXE_srcA_i / EXE_srcB_i  in  `SINGLE_WORD`  operands
- SBA_okToChange_w_o  out  1  stage can accept from EXE
- SBA_valid_w_o  out  1  result offered to REEXE
- SBA_forwardMode_w_o  out  1  result is forwardable
- SBA_writeNum_w_o  out  `GPR_NUM`  destination, used for hazard checks
- SBA_writeNum_o  out  `GPR_NUM`  registered destination
- SBA_VAddr_o  out  `SINGLE_WORD`  registered PC
- SBA_aluRes_o  out  `SINGLE_WORD`  result

## Operation
- Ops:
  - ADD, SUB: wrap-around; no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT, SLTU: result is 0 or 1.
  - SLL, SRL, SRA: shift amount is srcB[4:0].
  - LUI: {srcB[15:0], 16'b0}.
  - MUL: low 32 bits of the product.
  - DIV, DIVU: quotient.
  - MOD, MODU: remainder.
- Capture: when EXE_valid_w_i && SBA_okToChange_w_o, latch writeNum, VAddr, op and operands, and set hasData.
- If the stage can accept but EXE_valid_w_i=0, hasData clears and all registers go to 0.
- ready:
  - non-divide ops: ready=1.
  - divide ops: ready=(state==DONE).
- SBA_okToChange_w_o = !hasData || (ready && REEXE_okToChange_w_i).
- SBA_valid_w_o = hasData && ready.
- SBA_forwardMode_w_o = hasData && ready.
- Divider FSM:
  - IDLE: on capture of a divide op, go to BUSY with cnt=0. Exception: go straight to DONE on divisor==0 or signed -2^31/-1.
  - BUSY: one restoring step per cycle on magnitudes. Leave for DONE after the cnt==31 step.
  - DONE: hold until the stage is handed off (okToChange with no new divide), then go to IDLE. Back-to-back divide: DONE→BUSY directly.
- Sign fix-up for DIV/MOD: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Special divide results:
  - divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - -2^31/-1 (signed): quotient=0x80000000, remainder=0.
- flush_w_i has priority over capture and over the divider. Next edge: hasData=0, state=IDLE, all registers 0.

## Timing
- Reset (rst=0 at an edge):
  - hasData=0, state=IDLE, cnt=0, all registers 0.
  - Resulting outputs: SBA_valid_w_o=0, SBA_okToChange_w_o=1, all data outputs 0.
  - Reset mid-division abandons the operation.
- Latency (cycle 0 = first cycle with hasData=1):
  - non-divide: valid in cycle 0.
  - divide: BUSY in cycles 0–31, valid in cycle 32.
  - special-case divide: valid in cycle 0.
- Hold: while SBA_valid_w_o=1 and REEXE_okToChange_w_i=0, all outputs stay stable and okToChange=0.
- Streaming: with REEXE always ready, single-cycle ops sustain 1 instruction/cycle.
- While BUSY, SBA_okToChange_w_o=0 regardless of downstream.
- Flush in the same cycle as an EXE offer: the offer is dropped.

## Structure
- Shared defines file (existing header) holds `ALU_OP` width and the op encodings; `GPR_NUM` and `SINGLE_WORD` already exist there.
- Sub-module sba_divider:
  - holds the FSM, counter, and remainder/quotient shift registers.
  - ports: start, signed, dividend, divisor, flush, done, quotient, remainder.
- Top level holds the interlock, the stage registers and the combinational ALU mux.

## Test plan
- ADD 0x7FFFFFFF+1 with REEXE ready → valid in cycle 0, aluRes=0x80000000, writeNum passed through.
- DIV -7/2 → okToChange=0 for cycles 0–31; valid in cycle 32 with quotient 0xFFFFFFFD. MOD of the same operands gives 0xFFFFFFFF.
- DIVU 5/0 → valid in cycle 0, aluRes=0xFFFFFFFF. MODU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Result valid while REEXE_okToChange_w_i=0 for 3 cycles → outputs held and stable; on release, the next EXE op is captured at the same edge.
- flush_w_i asserted at BUSY cycle 10 → next cycle hasData=0, state=IDLE, okToChange=1; a following ADD completes in cycle 0.
- rst=0 for one edge mid-stream → all outputs 0, valid=0, okToChange=1 in the next cycle.

Source files
------------

// File: rtl/sba_stage_pkg.sv
// Shared types, ALU op encodings and the single-cycle ALU function for the SBA stage.
package sba_stage_pkg;

    typedef logic [4:0]  gpr_num_t;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  alu_op_t;

    localparam alu_op_t OP_ADD  = 5'd0;
    localparam alu_op_t OP_SUB  = 5'd1;
    localparam alu_op_t OP_AND  = 5'd2;
    localparam alu_op_t OP_OR   = 5'd3;
    localparam alu_op_t OP_XOR  = 5'd4;
    localparam alu_op_t OP_NOR  = 5'd5;
    localparam alu_op_t OP_SLT  = 5'd6;
    localparam alu_op_t OP_SLTU = 5'd7;
    localparam alu_op_t OP_SLL  = 5'd8;
    localparam alu_op_t OP_SRL  = 5'd9;
    localparam alu_op_t OP_SRA  = 5'd10;
    localparam alu_op_t OP_LUI  = 5'd11;
    localparam alu_op_t OP_MUL  = 5'd12;
    localparam alu_op_t OP_DIV  = 5'd13;
    localparam alu_op_t OP_DIVU = 5'd14;
    localparam alu_op_t OP_MOD  = 5'd15;
    localparam alu_op_t OP_MODU = 5'd16;

    typedef struct packed {
        gpr_num_t wnum;
        word_t    vaddr;
        alu_op_t  op;
        word_t    src_a;
        word_t    src_b;
    } stage_t;

    function automatic logic op_is_div(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MOD) || (op == OP_MODU);
    endfunction

    function automatic logic op_is_signed_div(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Divide ops return 0 here; their result comes from the divider.
    function automatic word_t alu_calc(input alu_op_t op, input word_t a, input word_t b);
        word_t res;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = {31'b0, ($signed(a) < $signed(b))};
            OP_SLTU: res = {31'b0, (a < b)};
            OP_SLL:  res = a << b[4:0];
            OP_SRL:  res = a >> b[4:0];
            OP_SRA:  res = word_t'($signed(a) >>> b[4:0]);
            OP_LUI:  res = {b[15:0], 16'h0000};
            OP_MUL:  res = a * b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sba_stage_if.sv
// EXE -> SBA -> REEXE handshake and data bundle; slave is the stage, master drives EXE/REEXE side.
interface sba_stage_if;
    import sba_stage_pkg::*;

    logic     EXE_valid_w_i;
    logic     REEXE_okToChange_w_i;
    logic     flush_w_i;
    gpr_num_t EXE_writeNum_i;
    word_t    EXE_VAddr_i;
    alu_op_t  EXE_aluOp_i;
    word_t    EXE_srcA_i;
    word_t    EXE_srcB_i;

    logic     SBA_okToChange_w_o;
    logic     SBA_valid_w_o;
    logic     SBA_forwardMode_w_o;
    gpr_num_t SBA_writeNum_w_o;
    gpr_num_t SBA_writeNum_o;
    word_t    SBA_VAddr_o;
    word_t    SBA_aluRes_o;

    modport slave (
        input  EXE_valid_w_i, REEXE_okToChange_w_i, flush_w_i,
        input  EXE_writeNum_i, EXE_VAddr_i, EXE_aluOp_i, EXE_srcA_i, EXE_srcB_i,
        output SBA_okToChange_w_o, SBA_valid_w_o, SBA_forwardMode_w_o,
        output SBA_writeNum_w_o, SBA_writeNum_o, SBA_VAddr_o, SBA_aluRes_o
    );

    modport master (
        output EXE_valid_w_i, REEXE_okToChange_w_i, flush_w_i,
        output EXE_writeNum_i, EXE_VAddr_i, EXE_aluOp_i, EXE_srcA_i, EXE_srcB_i,
        input  SBA_okToChange_w_o, SBA_valid_w_o, SBA_forwardMode_w_o,
        input  SBA_writeNum_w_o, SBA_writeNum_o, SBA_VAddr_o, SBA_aluRes_o
    );

endinterface

// File: rtl/sba_stage_divider.sv
// Iterative 32-step restoring divider with sign fix-up and divide-by-zero / overflow shortcuts.
//   state | meaning
//   IDLE  | no division in progress
//   BUSY  | one restoring step per cycle, cnt counts steps 0..31
//   DONE  | result valid, held until the stage hands it off
module sba_divider
    import sba_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    input  logic  signed_i,
    input  word_t dividend_i,
    input  word_t divisor_i,
    input  logic  flush_i,
    input  logic  advance_i,
    output logic  done_o,
    output word_t quotient_o,
    output word_t remainder_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    word_t      quo_q, quo_d;
    word_t      rem_q, rem_d;
    word_t      dvs_q, dvs_d;
    logic       neg_quo_q, neg_quo_d;
    logic       neg_rem_q, neg_rem_d;

    word_t       abs_a, abs_b, diff;
    logic [32:0] rem_shift;
    logic        fits;

    assign abs_a     = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    assign abs_b     = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
    assign rem_shift = {rem_q, quo_q[31]};
    assign fits      = rem_shift >= {1'b0, dvs_q};
    assign diff      = rem_shift[31:0] - dvs_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (flush_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            quo_d     = '0;
            rem_d     = '0;
            dvs_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
        end else if (start_i) begin
            cnt_d     = '0;
            dvs_d     = abs_b;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            if (divisor_i == '0) begin
                state_d = ST_DONE;
                quo_d   = '1;
                rem_d   = dividend_i;
            end else if (signed_i && dividend_i == 32'h8000_0000 && divisor_i == '1) begin
                state_d = ST_DONE;
                quo_d   = 32'h8000_0000;
                rem_d   = '0;
            end else begin
                state_d   = ST_BUSY;
                quo_d     = abs_a;
                rem_d     = '0;
                neg_quo_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
                neg_rem_d = signed_i && dividend_i[31];
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    rem_d = fits ? diff : rem_shift[31:0];
                    quo_d = {quo_q[30:0], fits};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = ST_DONE;
                end
                ST_DONE: if (advance_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign done_o      = (state_q == ST_DONE);
    assign quotient_o  = neg_quo_q ? -quo_q : quo_q;
    assign remainder_o = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/sba_stage.sv
// SBA pipeline stage: latches one EXE instruction, computes its ALU result and hands it to REEXE.
module sba_stage
    import sba_stage_pkg::*;
(
    input logic         clk,
    input logic         rst,
    sba_stage_if.slave  sba_io
);

    stage_t st_q, st_d;
    logic   has_data_q, has_data_d;

    logic   is_div_q, ready, ok_to_change, capture, div_start;
    logic   div_done;
    word_t  div_quo, div_rem, alu_res;

    assign is_div_q     = op_is_div(st_q.op);
    assign ready        = !is_div_q || div_done;
    assign ok_to_change = !has_data_q || (ready && sba_io.REEXE_okToChange_w_i);
    assign capture      = sba_io.EXE_valid_w_i && ok_to_change && !sba_io.flush_w_i;
    assign div_start    = capture && op_is_div(sba_io.EXE_aluOp_i);

    always_comb begin
        st_d       = st_q;
        has_data_d = has_data_q;
        if (sba_io.flush_w_i) begin
            st_d       = '0;
            has_data_d = 1'b0;
        end else if (ok_to_change) begin
            if (sba_io.EXE_valid_w_i) begin
                st_d = '{wnum:  sba_io.EXE_writeNum_i,
                         vaddr: sba_io.EXE_VAddr_i,
                         op:    sba_io.EXE_aluOp_i,
                         src_a: sba_io.EXE_srcA_i,
                         src_b: sba_io.EXE_srcB_i};
                has_data_d = 1'b1;
            end else begin
                st_d       = '0;
                has_data_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= '0;
            has_data_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            has_data_q <= has_data_d;
        end
    end

    // Divider operands come straight from EXE so the first step runs in cycle 0.
    sba_divider u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .signed_i    (op_is_signed_div(sba_io.EXE_aluOp_i)),
        .dividend_i  (sba_io.EXE_srcA_i),
        .divisor_i   (sba_io.EXE_srcB_i),
        .flush_i     (sba_io.flush_w_i),
        .advance_i   (ok_to_change),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        alu_res = alu_calc(st_q.op, st_q.src_a, st_q.src_b);
        case (st_q.op)
            OP_DIV, OP_DIVU: alu_res = div_quo;
            OP_MOD, OP_MODU: alu_res = div_rem;
            default: ;
        endcase
    end

    assign sba_io.SBA_okToChange_w_o  = ok_to_change;
    assign sba_io.SBA_valid_w_o       = has_data_q && ready;
    assign sba_io.SBA_forwardMode_w_o = has_data_q && ready;
    assign sba_io.SBA_writeNum_w_o    = st_q.wnum;
    assign sba_io.SBA_writeNum_o      = st_q.wnum;
    assign sba_io.SBA_VAddr_o         = st_q.vaddr;
    assign sba_io.SBA_aluRes_o        = alu_res;

endmodule
